input_rld_loader: RTL and testbench
===================================

Name: input_rld_loader

Overview:
- Upstream loader for the activation input buffer.
- Takes a zero-run-length-encoded activation stream of (run, value) tokens. Each token means "run zeros, then value".
- Expands the stream into the dense dual-port input buffer through both write ports, so zeros fill at 2 words/cycle.
- Signals done when the tile of len words, starting at base_addr, is fully written.

Parameters:
- DWIDTH, 12, activation word width; matches the input buffer.
- AWIDTH, 10, buffer address width.
- RWIDTH, 6, width of the zero-run field in a token.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a tile; ignored unless in IDLE.
- base_addr  in  AWIDTH  first buffer address of the tile; sampled on start.
- len  in  AWIDTH+1  tile length in words, 1..2^AWIDTH; sampled on start.
- in_valid  in  1  token valid.
- in_ready  out  1  token accepted when in_valid & in_ready.
- in_run  in  RWIDTH  number of zeros preceding in_data.
- in_data  in  DWIDTH  nonzero (or final) value.
- in_last  in  1  marks the final token of the tile.
- addr0, addr1  out  AWIDTH  buffer port addresses.
- ce0, ce1  out  1  buffer port enables.
- we0, we1  out  1  buffer write enables; always equal to ce when asserted.
- d0, d1  out  DWIDTH  buffer write data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the tile is complete.
- err  out  1  sticky overflow flag; cleared on start.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal cnt=0, zrem=0.
- Write offset cnt runs 0..len. Buffer address = (base_addr + cnt) mod 2^AWIDTH, so the tile wraps around the top of the buffer.
- Only registered outputs drive the ports. A write issued in cycle N lands in the buffer at edge N+1.
- IDLE: in_ready=0. On start, sample base_addr and len, clear cnt and err, go FETCH.
- FETCH: in_ready=1.
  - Accept with run=0: port0 writes in_data at cnt; cnt+=1. Go TAIL if in_last, else stay in FETCH (1 token/cycle).
  - Accept with run>0: latch zrem=run, the value and last; no write this cycle; go ZFILL.
- ZFILL: in_ready=0.
  - zrem>=2: port0 writes zero at cnt, port1 writes zero at cnt+1; cnt+=2; zrem-=2.
  - zrem==1: port0 writes zero at cnt, port1 writes the latched value at cnt+1; cnt+=2. Go TAIL if last, else FETCH.
  - zrem==0: port0 writes the value; cnt+=1. Go TAIL if last, else FETCH.
- TAIL: zero-fills cnt..len-1 two words per cycle, or one word on port0 when only one remains. When cnt>=len, go DONE.
- DONE: done=1 for one cycle, then IDLE.
- Overflow: any write whose offset >= len is suppressed (ce deasserted for that port) and err is set.
  - A token accepted with cnt>=len is dropped and sets err.
  - Tokens are still consumed until in_last.
- Port1 address is always port0 address +1 (mod 2^AWIDTH), so the two ports never target the same address.
- start while busy is ignored.
- Asynchronous reset mid-tile returns to IDLE immediately with ce0/ce1=0. No partial write completes after reset assertion.

Optional Feature:
- Macro: RLD_NNZ_COUNT_EN.
- Defined: adds output nnz_cnt [AWIDTH:0].
  - Cleared on start.
  - Incremented once per non-suppressed value write whose in_data != 0.
  - Valid and stable from the done pulse until the next start.
- Undefined: port absent; no counter logic.

Test Plan:
- Dense stream: base=0, len=4, tokens (0,5)(0,6)(0,7)(0,8,last) -> 4 consecutive port0 writes to addr 0..3; done 1 cycle after the last write; err=0.
- Even run: base=10, len=5, token (4,9,last) -> cycle1: zero@10 and zero@11; cycle2: zero@12 and zero@13; cycle3: 9@14; done; in_ready low throughout ZFILL.
- Odd run plus tail: base=0, len=8, token (3,0x7FF,last) -> zero@0,1; zero@2 with 0x7FF@3; tail zero@4,5 then zero@6,7; done.
- Wrap-around: base=1022, len=4, token (0,1)(2,3,last) -> 1@1022, zero@1023, zero@0, 3@1; addresses wrap.
- Overflow: len=2, token (3,4,last) -> zeros at offsets 0,1 written, rest suppressed; err=1; done still pulses; err clears on next start.
- Reset mid-ZFILL: assert rst_n=0 during a 20-zero run -> ce0/ce1/busy drop to 0 immediately; after release, state IDLE and in_ready=0.

Source files
------------

// File: rtl/input_rld_loader.sv
// input_rld_loader: expands a zero-run-length-encoded activation stream of
// (run, value) tokens into the dense dual-port input buffer. Zero runs are
// written two words per cycle through both ports. The tile of len words at
// base_addr wraps modulo 2^AWIDTH. Writes at offsets >= len are suppressed
// and raise the sticky err flag.
// Optional feature macro: RLD_NNZ_COUNT_EN adds the nnz_cnt output, which
// counts the nonzero value words written in the tile.
module input_rld_loader #(
   parameter int DWIDTH = 12,
   parameter int AWIDTH = 10,
   parameter int RWIDTH = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [AWIDTH-1:0] base_addr,
   input  logic [AWIDTH:0]   len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [RWIDTH-1:0] in_run,
   input  logic [DWIDTH-1:0] in_data,
   input  logic              in_last,
   output logic [AWIDTH-1:0] addr0,
   output logic [AWIDTH-1:0] addr1,
   output logic              ce0,
   output logic              ce1,
   output logic              we0,
   output logic              we1,
   output logic [DWIDTH-1:0] d0,
   output logic [DWIDTH-1:0] d1,
   output logic              busy,
   output logic              done,
   output logic              err
`ifdef RLD_NNZ_COUNT_EN
   ,
   output logic [AWIDTH:0]   nnz_cnt
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ZFILL, S_TAIL, S_DONE} state_t;

   localparam logic [AWIDTH:0] ONE = (AWIDTH+1)'(1);
   localparam logic [AWIDTH:0] TWO = (AWIDTH+1)'(2);

   state_t              state_q, state_d;
   logic [AWIDTH-1:0]   base_q, base_d;
   logic [AWIDTH:0]     len_q, len_d;
   logic [AWIDTH:0]     cnt_q, cnt_d;
   logic [RWIDTH-1:0]   zrem_q, zrem_d;
   logic [DWIDTH-1:0]   val_q, val_d;
   logic                last_q, last_d;
   logic                in_ready_q, in_ready_d;
   logic [AWIDTH-1:0]   addr0_q, addr0_d, addr1_q, addr1_d;
   logic                ce0_q, ce0_d, ce1_q, ce1_d;
   logic                we0_q, we0_d, we1_q, we1_d;
   logic [DWIDTH-1:0]   d0_q, d0_d, d1_q, d1_d;
   logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
`ifdef RLD_NNZ_COUNT_EN
   logic [AWIDTH:0]     nnz_q, nnz_d;
   logic                val_hit;
`endif

   logic                accept, wr0, wr1, ok0, ok1;
   logic [AWIDTH:0]     step;

   // Next-state, write-port and flag computation for the expansion FSM
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      zrem_d  = zrem_q;
      val_d   = val_q;
      last_d  = last_q;
      err_d   = err_q;
      wr0     = 1'b0;
      wr1     = 1'b0;
      step    = '0;
      d0_d    = '0;
      d1_d    = '0;
      accept  = in_valid && in_ready_q;
      ok0     = cnt_q < len_q;
      ok1     = (cnt_q + ONE) < len_q;
      addr0_d = base_q + cnt_q[AWIDTH-1:0];
      addr1_d = addr0_d + AWIDTH'(1);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d  = base_addr;
               len_d   = len;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (accept) begin
               if (in_run == '0) begin
                  wr0  = 1'b1;
                  d0_d = in_data;
                  step = ONE;
                  if (in_last) state_d = S_TAIL;
               end else begin
                  zrem_d  = in_run;
                  val_d   = in_data;
                  last_d  = in_last;
                  state_d = S_ZFILL;
                  if (!ok0) err_d = 1'b1;
               end
            end
         end
         S_ZFILL: begin
            if (zrem_q >= RWIDTH'(2)) begin
               wr0    = 1'b1;
               wr1    = 1'b1;
               step   = TWO;
               zrem_d = zrem_q - RWIDTH'(2);
            end else if (zrem_q == RWIDTH'(1)) begin
               wr0     = 1'b1;
               wr1     = 1'b1;
               d1_d    = val_q;
               step    = TWO;
               zrem_d  = '0;
               state_d = last_q ? S_TAIL : S_FETCH;
            end else begin
               wr0     = 1'b1;
               d0_d    = val_q;
               step    = ONE;
               state_d = last_q ? S_TAIL : S_FETCH;
            end
         end
         S_TAIL: begin
            if (!ok0) begin
               state_d = S_DONE;
            end else begin
               wr0  = 1'b1;
               wr1  = ok1;
               step = ok1 ? TWO : ONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Out-of-tile writes are dropped; cnt stops once it reaches len so it
      // cannot wrap however many tokens arrive after the overflow.
      ce0_d = wr0 && ok0;
      ce1_d = wr1 && ok1;
      we0_d = ce0_d;
      we1_d = ce1_d;
      if ((wr0 && !ok0) || (wr1 && !ok1)) err_d = 1'b1;
      if (state_q != S_IDLE && ok0) cnt_d = cnt_q + step;

      in_ready_d = (state_d == S_FETCH);
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);

`ifdef RLD_NNZ_COUNT_EN
      val_hit = (state_q == S_FETCH && accept && in_run == '0 && ce0_d && in_data != '0) ||
                (state_q == S_ZFILL && zrem_q == RWIDTH'(1) && ce1_d && val_q != '0) ||
                (state_q == S_ZFILL && zrem_q == '0 && ce0_d && val_q != '0);
      nnz_d = nnz_q;
      if (state_q == S_IDLE && start) nnz_d = '0;
      else if (val_hit)               nnz_d = nnz_q + ONE;
`endif
   end

   // State and registered outputs; reset drops all writes immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         zrem_q     <= '0;
         val_q      <= '0;
         last_q     <= 1'b0;
         in_ready_q <= 1'b0;
         addr0_q    <= '0;
         addr1_q    <= '0;
         ce0_q      <= 1'b0;
         ce1_q      <= 1'b0;
         we0_q      <= 1'b0;
         we1_q      <= 1'b0;
         d0_q       <= '0;
         d1_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef RLD_NNZ_COUNT_EN
         nnz_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         zrem_q     <= zrem_d;
         val_q      <= val_d;
         last_q     <= last_d;
         in_ready_q <= in_ready_d;
         addr0_q    <= addr0_d;
         addr1_q    <= addr1_d;
         ce0_q      <= ce0_d;
         ce1_q      <= ce1_d;
         we0_q      <= we0_d;
         we1_q      <= we1_d;
         d0_q       <= d0_d;
         d1_q       <= d1_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
`ifdef RLD_NNZ_COUNT_EN
         nnz_q      <= nnz_d;
`endif
      end
   end

   assign in_ready = in_ready_q;
   assign addr0    = addr0_q;
   assign addr1    = addr1_q;
   assign ce0      = ce0_q;
   assign ce1      = ce1_q;
   assign we0      = we0_q;
   assign we1      = we1_q;
   assign d0       = d0_q;
   assign d1       = d1_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
`ifdef RLD_NNZ_COUNT_EN
   assign nnz_cnt  = nnz_q;
`endif

endmodule

// File: tb/tb_input_rld_loader.sv
// Directed testbench for input_rld_loader: logs every buffer write with its
// cycle number and compares against hand-computed write sequences.
module tb_input_rld_loader;
   localparam int DW = 12;
   localparam int AW = 10;
   localparam int RW = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   len;
   logic          in_valid;
   logic          in_ready;
   logic [RW-1:0] in_run;
   logic [DW-1:0] in_data;
   logic          in_last;
   logic [AW-1:0] addr0, addr1;
   logic          ce0, ce1, we0, we1;
   logic [DW-1:0] d0, d1;
   logic          busy, done, err;
`ifdef RLD_NNZ_COUNT_EN
   logic [AW:0]   nnz_cnt;
`endif

   input_rld_loader #(.DWIDTH(DW), .AWIDTH(AW), .RWIDTH(RW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
      .in_valid(in_valid), .in_ready(in_ready), .in_run(in_run), .in_data(in_data),
      .in_last(in_last), .addr0(addr0), .addr1(addr1), .ce0(ce0), .ce1(ce1),
      .we0(we0), .we1(we1), .d0(d0), .d1(d1), .busy(busy), .done(done), .err(err)
`ifdef RLD_NNZ_COUNT_EN
      , .nnz_cnt(nnz_cnt)
`endif
   );

   always #5 clk = ~clk;

   int nvec  = 0;
   int nfail = 0;
   int cyc   = 0;

   typedef struct {int cyc; int port; int addr; int data;} wr_t;
   wr_t log_q[$];
   int  done_cyc;
   int  done_n;
   bit  done_seen;

   always @(posedge clk) cyc <= cyc + 1;

   // Write/done logger sampled away from the active edge
   always @(negedge clk) begin
      if (ce0) log_q.push_back('{cyc, 0, int'(addr0), int'(d0)});
      if (ce1) log_q.push_back('{cyc, 1, int'(addr1), int'(d1)});
      if (done) begin
         done_cyc  = cyc;
         done_seen = 1'b1;
         done_n++;
      end
   end

   function automatic logic [63:0] pk(input int rel, input int port, input int addr, input int data);
      return {16'(rel), 16'(port), 16'(addr), 16'(data)};
   endfunction

   task automatic do_start(input int base, input int ln);
      @(negedge clk);
      base_addr = AW'(base);
      len       = (AW+1)'(ln);
      start     = 1'b1;
      log_q.delete();
      done_seen = 1'b0;
      done_n    = 0;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic send(input int run, input int data, input bit last, output bit ok);
      in_run   = RW'(run);
      in_data  = DW'(data);
      in_last  = last;
      in_valid = 1'b1;
      ok       = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
      end
      if (ok) @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      for (int i = 0; i < 200 && !done_seen; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      ok = done_seen;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b0; base_addr = '0; len = '0;
      in_valid = 1'b0; in_run = '0; in_data = '0; in_last = 1'b0;
      repeat (2) @(negedge clk);
      nvec++;
      if ({in_ready, ce0, ce1, we0, we1, busy, done, err, addr0, addr1, d0, d1} !== '0)
         begin nfail++; $display("FAIL reset_outputs: got in_ready=%b ce=%b%b busy=%b err=%b addr0=%0d, want all 0", in_ready, ce0, ce1, busy, err, addr0); end
      rst_n = 1'b1;
      @(negedge clk);
      nvec++;
      if ({in_ready, busy, done, ce0, ce1} !== 5'b0)
         begin nfail++; $display("FAIL reset_release: got in_ready=%b busy=%b done=%b, want 0", in_ready, busy, done); end
   endtask

   task automatic test_dense;
      logic [63:0] exp[4];
      logic [63:0] got;
      bit o1, o2, o3, o4, od;
      int c0;
      exp = '{pk(0,0,0,5), pk(1,0,1,6), pk(2,0,2,7), pk(3,0,3,8)};
      do_start(0, 4);
      send(0, 5, 0, o1); send(0, 6, 0, o2); send(0, 7, 0, o3); send(0, 8, 1, o4);
      wait_done(od);
      nvec++;
      if (!(o1 && o2 && o3 && o4 && od)) begin nfail++; $display("FAIL dense_timeout: got accepted=%b%b%b%b done=%b, want 11111", o1, o2, o3, o4, od); end
      nvec++;
      if (log_q.size() != 4) begin nfail++; $display("FAIL dense_count: got %0d writes, want 4", log_q.size()); end
      c0 = (log_q.size() > 0) ? log_q[0].cyc : 0;
      for (int i = 0; i < 4 && i < log_q.size(); i++) begin
         got = pk(log_q[i].cyc - c0, log_q[i].port, log_q[i].addr, log_q[i].data);
         nvec++;
         if (got !== exp[i]) begin nfail++; $display("FAIL dense_wr%0d: got %h, want %h", i, got, exp[i]); end
      end
      nvec++;
      if (done_cyc - c0 != 4 || done_n != 1) begin nfail++; $display("FAIL dense_done: got rel %0d count %0d, want rel 4 count 1", done_cyc - c0, done_n); end
      nvec++;
      if (err !== 1'b0) begin nfail++; $display("FAIL dense_err: got %b, want 0", err); end
`ifdef RLD_NNZ_COUNT_EN
      nvec++;
      if (nnz_cnt !== 11'd4) begin nfail++; $display("FAIL dense_nnz: got %0d, want 4", nnz_cnt); end
`endif
   endtask

   task automatic test_even_run;
      logic [63:0] exp[5];
      logic [63:0] got;
      bit o1, od;
      int c0;
      exp = '{pk(0,0,10,0), pk(0,1,11,0), pk(1,0,12,0), pk(1,1,13,0), pk(2,0,14,9)};
      do_start(10, 5);
      send(4, 9, 1, o1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         nvec++;
         if (in_ready !== 1'b0) begin nfail++; $display("FAIL even_ready%0d: got %b, want 0", i, in_ready); end
         // start while busy must be ignored
         start = (i == 0); base_addr = AW'(500); len = (AW+1)'(3);
      end
      start = 1'b0;
      wait_done(od);
      nvec++;
      if (!(o1 && od)) begin nfail++; $display("FAIL even_timeout: got accepted=%b done=%b, want 11", o1, od); end
      nvec++;
      if (log_q.size() != 5) begin nfail++; $display("FAIL even_count: got %0d writes, want 5", log_q.size()); end
      c0 = (log_q.size() > 0) ? log_q[0].cyc : 0;
      for (int i = 0; i < 5 && i < log_q.size(); i++) begin
         got = pk(log_q[i].cyc - c0, log_q[i].port, log_q[i].addr, log_q[i].data);
         nvec++;
         if (got !== exp[i]) begin nfail++; $display("FAIL even_wr%0d: got %h, want %h", i, got, exp[i]); end
      end
      nvec++;
      if (done_cyc - c0 != 3) begin nfail++; $display("FAIL even_done: got rel %0d, want 3", done_cyc - c0); end
   endtask

   task automatic test_odd_tail;
      logic [63:0] exp[8];
      logic [63:0] got;
      bit o1, od;
      int c0;
      exp = '{pk(0,0,0,0), pk(0,1,1,0), pk(1,0,2,0), pk(1,1,3,12'h7FF),
              pk(2,0,4,0), pk(2,1,5,0), pk(3,0,6,0), pk(3,1,7,0)};
      do_start(0, 8);
      send(3, 12'h7FF, 1, o1);
      wait_done(od);
      nvec++;
      if (!(o1 && od)) begin nfail++; $display("FAIL odd_timeout: got accepted=%b done=%b, want 11", o1, od); end
      nvec++;
      if (log_q.size() != 8) begin nfail++; $display("FAIL odd_count: got %0d writes, want 8", log_q.size()); end
      c0 = (log_q.size() > 0) ? log_q[0].cyc : 0;
      for (int i = 0; i < 8 && i < log_q.size(); i++) begin
         got = pk(log_q[i].cyc - c0, log_q[i].port, log_q[i].addr, log_q[i].data);
         nvec++;
         if (got !== exp[i]) begin nfail++; $display("FAIL odd_wr%0d: got %h, want %h", i, got, exp[i]); end
      end
      nvec++;
      if (done_cyc - c0 != 4) begin nfail++; $display("FAIL odd_done: got rel %0d, want 4", done_cyc - c0); end
`ifdef RLD_NNZ_COUNT_EN
      nvec++;
      if (nnz_cnt !== 11'd1) begin nfail++; $display("FAIL odd_nnz: got %0d, want 1", nnz_cnt); end
`endif
   endtask

   task automatic test_wrap;
      logic [63:0] exp[4];
      logic [63:0] got;
      bit o1, o2, od;
      int c0;
      exp = '{pk(0,0,1022,1), pk(2,0,1023,0), pk(2,1,0,0), pk(3,0,1,3)};
      do_start(1022, 4);
      send(0, 1, 0, o1); send(2, 3, 1, o2);
      wait_done(od);
      nvec++;
      if (!(o1 && o2 && od)) begin nfail++; $display("FAIL wrap_timeout: got accepted=%b%b done=%b, want 111", o1, o2, od); end
      nvec++;
      if (log_q.size() != 4) begin nfail++; $display("FAIL wrap_count: got %0d writes, want 4", log_q.size()); end
      c0 = (log_q.size() > 0) ? log_q[0].cyc : 0;
      for (int i = 0; i < 4 && i < log_q.size(); i++) begin
         got = pk(log_q[i].cyc - c0, log_q[i].port, log_q[i].addr, log_q[i].data);
         nvec++;
         if (got !== exp[i]) begin nfail++; $display("FAIL wrap_wr%0d: got %h, want %h", i, got, exp[i]); end
      end
      nvec++;
      if (done_cyc - c0 != 4) begin nfail++; $display("FAIL wrap_done: got rel %0d, want 4", done_cyc - c0); end
`ifdef RLD_NNZ_COUNT_EN
      nvec++;
      if (nnz_cnt !== 11'd2) begin nfail++; $display("FAIL wrap_nnz: got %0d, want 2", nnz_cnt); end
`endif
   endtask

   task automatic test_overflow;
      logic [63:0] exp[2];
      logic [63:0] got;
      bit o1, o2, od;
      int c0;
      exp = '{pk(0,0,0,0), pk(0,1,1,0)};
      do_start(0, 2);
      send(3, 4, 1, o1);
      wait_done(od);
      nvec++;
      if (!(o1 && od)) begin nfail++; $display("FAIL ovf_timeout: got accepted=%b done=%b, want 11", o1, od); end
      nvec++;
      if (log_q.size() != 2) begin nfail++; $display("FAIL ovf_count: got %0d writes, want 2", log_q.size()); end
      c0 = (log_q.size() > 0) ? log_q[0].cyc : 0;
      for (int i = 0; i < 2 && i < log_q.size(); i++) begin
         got = pk(log_q[i].cyc - c0, log_q[i].port, log_q[i].addr, log_q[i].data);
         nvec++;
         if (got !== exp[i]) begin nfail++; $display("FAIL ovf_wr%0d: got %h, want %h", i, got, exp[i]); end
      end
      nvec++;
      if (done_cyc - c0 != 2) begin nfail++; $display("FAIL ovf_done: got rel %0d, want 2", done_cyc - c0); end
      nvec++;
      if (err !== 1'b1) begin nfail++; $display("FAIL ovf_err_set: got %b, want 1", err); end
`ifdef RLD_NNZ_COUNT_EN
      nvec++;
      if (nnz_cnt !== 11'd0) begin nfail++; $display("FAIL ovf_nnz: got %0d, want 0", nnz_cnt); end
`endif
      do_start(5, 1);
      nvec++;
      if (err !== 1'b0) begin nfail++; $display("FAIL ovf_err_clear: got %b, want 0", err); end
      send(0, 3, 1, o2);
      wait_done(od);
      nvec++;
      if (!(o2 && od) || log_q.size() != 1 || err !== 1'b0)
         begin nfail++; $display("FAIL ovf_next_tile: got accepted=%b done=%b writes=%0d err=%b, want 1 1 1 0", o2, od, log_q.size(), err); end
   endtask

   task automatic test_reset_mid_zfill;
      bit o1;
      do_start(0, 64);
      send(20, 1, 1, o1);
      repeat (3) @(negedge clk);
      nvec++;
      if (!(o1 && ce0 === 1'b1 && ce1 === 1'b1)) begin nfail++; $display("FAIL rst_pre: got accepted=%b ce=%b%b, want 1 11", o1, ce0, ce1); end
      rst_n = 1'b0;
      #1;
      nvec++;
      if ({ce0, ce1, busy} !== 3'b000) begin nfail++; $display("FAIL rst_async: got ce=%b%b busy=%b, want 000", ce0, ce1, busy); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      nvec++;
      if ({in_ready, busy, ce0, ce1} !== 4'b0000) begin nfail++; $display("FAIL rst_idle: got in_ready=%b busy=%b ce=%b%b, want 0000", in_ready, busy, ce0, ce1); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_dense();
      test_even_run();
      test_odd_tail();
      test_wrap();
      test_overflow();
      test_reset_mid_zfill();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
